// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared constants for the instruction-memory loader: the FSM state
//   encodings, the frame field widths and the default inter-byte timeout.
//   No ports; imported by the interface, the loader top and the word packer.
package imem_loader_pkg;

  // FSM state encodings (3-bit, kept as plain constants for legacy tools)
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN0 = 3'd1;
  localparam logic [2:0] ST_LEN1 = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  // Frame fields
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int LEN_W          = 16;

  localparam int DEFAULT_TIMEOUT_CYC = 1_000_000;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Bundles the loader's control, byte-stream and imem write-port signals.
//   Parameter ADDR_W: imem word-address width.
//   Modports:
//     slave  - the loader: takes start/rx_data/rx_valid, drives the imem
//              write port and the status flags.
//     master - the surrounding system (receiver, host, core, imem).
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 14
);
  logic                start;
  logic [BYTE_W-1:0]   rx_data;
  logic                rx_valid;
  logic                imem_we;
  logic [ADDR_W-1:0]   imem_addr;
  logic [WORD_W-1:0]   imem_wdata;
  logic                cpu_hold;
  logic                load_done;
  logic                load_err;

  modport slave (
    input  start, rx_data, rx_valid,
    output imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
  );

  modport master (
    output start, rx_data, rx_valid,
    input  imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/imem_loader_word_packer.sv
// word_packer
//   Assembles little-endian bytes into 32-bit words and keeps the running
//   XOR checksum of every byte it accepts.
//   Ports:
//     clk, rst    clock, asynchronous active-low reset
//     clr         clears byte index, lanes and checksum (start of a frame)
//     byte_valid  accept rx_byte this cycle
//     rx_byte     incoming byte
//     word        assembled word, including the byte arriving this cycle
//     word_ready  this cycle's byte completes a word
//     csum        XOR of all bytes accepted since clr
module word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] rx_byte,
  output logic [WORD_W-1:0] word,
  output logic              word_ready,
  output logic [BYTE_W-1:0] csum
);
  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0]  k_q, k_d;
  logic [BYTE_W-1:0] csum_q, csum_d;

  // Byte index wraps naturally from 3 back to 0 after each word.
  always_comb begin
    k_d    = k_q;
    csum_d = csum_q;
    if (clr) begin
      k_d    = '0;
      csum_d = '0;
    end else if (byte_valid) begin
      k_d    = k_q + IDX_W'(1);
      csum_d = csum_q ^ rx_byte;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q    <= '0;
      csum_q <= '0;
    end else begin
      k_q    <= k_d;
      csum_q <= csum_d;
    end
  end

  assign word_ready = byte_valid && (k_q == IDX_W'(BYTES_PER_WORD - 1));
  assign csum       = csum_q;

  // One register per byte lane; the lane being written this cycle is
  // bypassed so the full word is available together with word_ready.
  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
    logic [BYTE_W-1:0] lane_q, lane_d;
    logic              hit;

    assign hit = byte_valid && (k_q == IDX_W'(gi));

    always_comb begin
      lane_d = lane_q;
      if (clr)      lane_d = '0;
      else if (hit) lane_d = rx_byte;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) lane_q <= '0;
      else      lane_q <= lane_d;
    end

    assign word[gi*BYTE_W +: BYTE_W] = hit ? rx_byte : lane_q;
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Receives a program frame (16-bit LE word count, LE 32-bit words, XOR
//   checksum byte) from a byte stream, writes the words to imem from word
//   address 0 upwards and holds the core while loading or after a failure.
//   Parameters: ADDR_W (imem word-address width), TIMEOUT_CYC (max idle
//   cycles between bytes of one frame).
//   Ports:
//     clk  clock, rising edge
//     rst  asynchronous active-low reset
//     bus  imem_loader_if.slave: start, rx_data/rx_valid in; imem_we,
//          imem_addr, imem_wdata, cpu_hold, load_done, load_err out
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
)
(
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);
  localparam int TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam int LEN_X_W  = LEN_W + 1;
  localparam int IDX_W    = ADDR_W + 1;
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [LEN_X_W-1:0] MAX_LEN = LEN_X_W'(1) << ADDR_W;

  logic [2:0]        state_q, state_d;
  logic [BYTE_W-1:0] len_lo_q, len_lo_d;
  logic [IDX_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [LEN_W-1:0]  len_full;
  logic [IDX_W-1:0]  idx_inc;
  logic              go_err;
  logic              pk_clr, pk_valid, pk_ready;
  logic [WORD_W-1:0] pk_word;
  logic [BYTE_W-1:0] pk_csum;

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .byte_valid (pk_valid),
    .rx_byte    (bus.rx_data),
    .word       (pk_word),
    .word_ready (pk_ready),
    .csum       (pk_csum)
  );

  assign len_full = {bus.rx_data, len_lo_q};
  // Index and length carry one extra bit so a full 2^ADDR_W image
  // terminates on the compare instead of wrapping the address.
  assign idx_inc  = idx_q + IDX_W'(1);

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    idx_d    = idx_q;
    to_d     = to_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hold_d   = hold_q;
    done_d   = done_q;
    err_d    = err_q;
    go_err   = 1'b0;
    pk_clr   = 1'b0;
    pk_valid = 1'b0;

    // Inter-byte timeout, only while a frame is being received.
    if (state_q == ST_LEN0 || state_q == ST_LEN1 ||
        state_q == ST_DATA || state_q == ST_CSUM) begin
      if (bus.rx_valid)        to_d   = '0;
      else if (to_q == TO_LAST) go_err = 1'b1;
      else                     to_d   = to_q + TO_W'(1);
    end

    case (state_q)
      ST_IDLE, ST_ERR: begin
        // Bytes arriving here (even with start) are dropped.
        if (bus.start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          idx_d   = '0;
          to_d    = '0;
          pk_clr  = 1'b1;
          state_d = ST_LEN0;
        end
      end
      ST_LEN0: begin
        if (bus.rx_valid) begin
          len_lo_d = bus.rx_data;
          state_d  = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (bus.rx_valid) begin
          len_d = len_full[IDX_W-1:0];
          if ({1'b0, len_full} > MAX_LEN) go_err  = 1'b1;
          else if (len_full == '0)        state_d = ST_CSUM;
          else                            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        pk_valid = bus.rx_valid;
        if (bus.rx_valid && pk_ready) begin
          we_d    = 1'b1;
          addr_d  = idx_q[ADDR_W-1:0];
          wdata_d = pk_word;
          idx_d   = idx_inc;
          if (idx_inc == len_q) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == pk_csum) begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            go_err = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_err) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
      hold_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      len_lo_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      to_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      to_q     <= to_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.load_done  = done_q;
  assign bus.load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed bench for imem_loader with ADDR_W=4 and TIMEOUT_CYC=16.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(4)) bus ();

  imem_loader #(.ADDR_W(4), .TIMEOUT_CYC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  // Write log captured from the imem port
  int          wr_cnt = 0;
  logic [31:0] wr_addr [128];
  logic [31:0] wr_data [128];

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (wr_cnt < 128) begin
        wr_addr[wr_cnt] <= 32'(bus.imem_addr);
        wr_data[wr_cnt] <= bus.imem_wdata;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    32'(bus.imem_we),   32'd0);
    check({tag, "_addr"},  32'(bus.imem_addr), 32'd0);
    check({tag, "_wdata"}, bus.imem_wdata,     32'd0);
    check({tag, "_hold"},  32'(bus.cpu_hold),  32'd0);
    check({tag, "_done"},  32'(bus.load_done), 32'd0);
    check({tag, "_err"},   32'(bus.load_err),  32'd0);
  endtask

  initial begin
    int          base;
    logic [7:0]  b;
    logic [7:0]  x;

    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Bytes in IDLE are ignored
    send_byte(8'h02);
    send_byte(8'h00);
    tick();
    check("idle_bytes_no_write", 32'(wr_cnt), 32'd0);
    check("idle_bytes_hold", 32'(bus.cpu_hold), 32'd0);

    // Nominal load, with a stray start pulse between words
    pulse_start();
    check("nom_hold_rise", 32'(bus.cpu_hold), 32'd1);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h00000013);
    check("nom_w0_we", 32'(bus.imem_we), 32'd1);
    check("nom_w0_addr", 32'(bus.imem_addr), 32'd0);
    check("nom_w0_data", bus.imem_wdata, 32'h00000013);
    pulse_start();
    send_word(32'h00A00093);
    check("nom_w1_we", 32'(bus.imem_we), 32'd1);
    check("nom_w1_addr", 32'(bus.imem_addr), 32'd1);
    check("nom_w1_data", bus.imem_wdata, 32'h00A00093);
    send_byte(8'h20);
    check("nom_done", 32'(bus.load_done), 32'd1);
    check("nom_hold", 32'(bus.cpu_hold), 32'd0);
    check("nom_err", 32'(bus.load_err), 32'd0);
    check("nom_wr_cnt", 32'(wr_cnt), 32'd2);
    check("nom_log_data0", wr_data[0], 32'h00000013);
    check("nom_log_data1", wr_data[1], 32'h00A00093);

    // Bad checksum, then recovery from ERR
    pulse_start();
    check("bad_done_cleared", 32'(bus.load_done), 32'd0);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h00000013);
    send_word(32'h00A00093);
    send_byte(8'h21);
    check("bad_err", 32'(bus.load_err), 32'd1);
    check("bad_hold", 32'(bus.cpu_hold), 32'd1);
    check("bad_done", 32'(bus.load_done), 32'd0);
    check("bad_wr_cnt", 32'(wr_cnt), 32'd4);
    repeat (20) tick();
    check("bad_hold_sticky", 32'(bus.cpu_hold), 32'd1);
    check("bad_err_sticky", 32'(bus.load_err), 32'd1);
    pulse_start();
    check("rec_err_cleared", 32'(bus.load_err), 32'd0);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h00000013);
    send_word(32'h00A00093);
    send_byte(8'h20);
    check("rec_done", 32'(bus.load_done), 32'd1);
    check("rec_err", 32'(bus.load_err), 32'd0);
    check("rec_hold", 32'(bus.cpu_hold), 32'd0);

    // Zero length
    base = wr_cnt;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check("zero_done", 32'(bus.load_done), 32'd1);
    check("zero_no_write", 32'(wr_cnt), 32'(base));

    // Over length: 17 > 2^4
    pulse_start();
    send_byte(8'h11);
    send_byte(8'h00);
    check("over_err", 32'(bus.load_err), 32'd1);
    check("over_hold", 32'(bus.cpu_hold), 32'd1);

    // Full-size image (len == 2^ADDR_W) with rx_valid every cycle
    base = wr_cnt;
    pulse_start();
    x = 8'h00;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h10;
    tick();
    bus.rx_data  = 8'h00;
    tick();
    for (int j = 0; j < 64; j++) begin
      b = 8'(j * 7 + 1);
      x = x ^ b;
      bus.rx_data = b;
      tick();
    end
    bus.rx_data = x;
    tick();
    bus.rx_valid = 1'b0;
    check("full_done", 32'(bus.load_done), 32'd1);
    check("full_err", 32'(bus.load_err), 32'd0);
    check("full_wr_cnt", 32'(wr_cnt), 32'(base + 16));
    check("full_first_addr", wr_addr[base], 32'd0);
    check("full_first_data", wr_data[base], 32'h160F0801);
    check("full_last_addr", wr_addr[base + 15], 32'd15);
    check("full_last_data", wr_data[base + 15], 32'hBAB3ACA5);

    // Timeout after three data bytes
    base = wr_cnt;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (15) tick();
    check("to_err_before", 32'(bus.load_err), 32'd0);
    tick();
    check("to_err_at_16", 32'(bus.load_err), 32'd1);
    check("to_hold", 32'(bus.cpu_hold), 32'd1);
    check("to_no_partial_write", 32'(wr_cnt), 32'(base));

    // Asynchronous reset between bytes 1 and 2 of word 0
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("arst");
    tick();
    rst = 1'b1;
    tick();
    base = wr_cnt;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'hDEADBEEF);
    check("arst_re_we", 32'(bus.imem_we), 32'd1);
    check("arst_re_addr", 32'(bus.imem_addr), 32'd0);
    check("arst_re_data", bus.imem_wdata, 32'hDEADBEEF);
    send_byte(8'h22);
    check("arst_re_done", 32'(bus.load_done), 32'd1);
    check("arst_re_wr_cnt", 32'(wr_cnt), 32'(base + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
